// File: rtl/fft_seq_pkg.sv
// Shared types, default widths and helpers for the FFT peak sequencer.
package fft_seq_pkg;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_IDX_W  = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int DIFF_W     = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LOCKED, ST_FAULT} seq_state_e;

    // Plain unsigned distance between bins; no wrap-around between 0 and max bin.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction
endpackage

// File: rtl/fft_peak_sequencer_if.sv
// ADC sample stream plus FFT core handshake, seen from the sequencer (slave) and its environment (master).
interface fft_peak_sequencer_if import fft_seq_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              core_clk_enable;
    logic [DATA_W-1:0] core_rx_in;
    logic              core_ce_out;
    logic              core_valid_out;
    logic [IDX_W-1:0]  core_index_max;

    modport master (
        output s_valid, s_data, core_ce_out, core_valid_out, core_index_max,
        input  s_ready, core_clk_enable, core_rx_in
    );
    modport slave (
        input  s_valid, s_data, core_ce_out, core_valid_out, core_index_max,
        output s_ready, core_clk_enable, core_rx_in
    );
endinterface

// File: rtl/fft_peak_qualifier.sv
// Tracks agreement of successive peak bins and produces lock / loss decisions and pulses.
module fft_peak_qualifier import fft_seq_pkg::*; #(
    parameter int IDX_W    = DEF_IDX_W,
    parameter int STABLE_N = 4,
    parameter int TOL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             res_vld,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             in_run,
    input  logic             in_locked,
    output logic             lock_hit,
    output logic             loss_hit,
    output logic [IDX_W-1:0] peak_index,
    output logic             peak_valid,
    output logic             peak_lost
);
    logic [IDX_W-1:0]  last_idx;
    logic [3:0]        stable_cnt;
    logic              first;
    logic [DIFF_W-1:0] diff;
    logic              agree;

    assign diff  = abs_diff(DIFF_W'(res_idx), DIFF_W'(last_idx));
    assign agree = !first && (diff <= DIFF_W'(TOL));
    // Decided in the result cycle so the pulse and state change land one cycle later.
    assign lock_hit = res_vld && in_run && agree && (stable_cnt == 4'(STABLE_N - 1));
    assign loss_hit = res_vld && in_locked && !agree;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx   <= '0;
            stable_cnt <= '0;
            first      <= 1'b1;
            peak_index <= '0;
            peak_valid <= 1'b0;
            peak_lost  <= 1'b0;
        end else begin
            peak_valid <= lock_hit;
            peak_lost  <= loss_hit;
            if (lock_hit) peak_index <= last_idx;
            if (clear) begin
                last_idx   <= '0;
                stable_cnt <= '0;
                first      <= 1'b1;
            end else if (res_vld) begin
                first <= 1'b0;
                if (!agree) begin
                    stable_cnt <= 4'd1;
                    last_idx   <= res_idx;
                end else if (in_run && stable_cnt != 4'hF) begin
                    stable_cnt <= stable_cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/fft_peak_sequencer.sv
// Gates the FFT core from the ADC stream, supervises result timeout and wraps the peak qualifier.
module fft_peak_sequencer import fft_seq_pkg::*; #(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int IDX_W           = DEF_IDX_W,
    parameter int STABLE_N        = 4,
    parameter int TOL             = 1,
    parameter int TIMEOUT_SAMPLES = 4096,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    fft_peak_sequencer_if.slave  bus,
    output logic [IDX_W-1:0]     peak_index,
    output logic                 peak_valid,
    output logic                 peak_lost,
    output logic                 locked,
    output logic                 fault,
    output logic [CNT_W-1:0]     result_count
);
    seq_state_e        state, state_next;
    logic              active, acc, res, clear, tmo_hit, lock_hit, loss_hit;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              cke_q;
    logic [DATA_W-1:0] rx_q;

    assign active  = (state == ST_RUN) || (state == ST_LOCKED);
    assign acc     = bus.s_valid && active && !stop;
    assign res     = bus.core_valid_out && bus.core_ce_out && active && !stop;
    assign clear   = (state == ST_IDLE) && start && !stop;
    // A result in the terminal-count cycle resets the counter instead of faulting.
    assign tmo_hit = acc && !res && (tmo_cnt == CNT_W'(TIMEOUT_SAMPLES - 1));

    assign bus.s_ready         = active;
    assign bus.core_clk_enable = cke_q;
    assign bus.core_rx_in      = rx_q;
    assign locked              = (state == ST_LOCKED);
    assign fault               = (state == ST_FAULT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_RUN;
            ST_RUN:    if (lock_hit) state_next = ST_LOCKED;
                       else if (tmo_hit) state_next = ST_FAULT;
            ST_LOCKED: if (loss_hit) state_next = ST_RUN;
                       else if (tmo_hit) state_next = ST_FAULT;
            default:   state_next = state;
        endcase
        if (stop) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cke_q        <= 1'b0;
            rx_q         <= '0;
            tmo_cnt      <= '0;
            result_count <= '0;
        end else begin
            state <= state_next;
            cke_q <= acc;
            if (acc) rx_q <= bus.s_data;
            if (clear) begin
                tmo_cnt      <= '0;
                result_count <= '0;
            end else if (res) begin
                tmo_cnt <= '0;
                if (result_count != '1) result_count <= result_count + 1'b1;
            end else if (acc) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    fft_peak_qualifier #(
        .IDX_W    (IDX_W),
        .STABLE_N (STABLE_N),
        .TOL      (TOL)
    ) u_qual (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .res_vld    (res),
        .res_idx    (bus.core_index_max),
        .in_run     (state == ST_RUN),
        .in_locked  (state == ST_LOCKED),
        .lock_hit   (lock_hit),
        .loss_hit   (loss_hit),
        .peak_index (peak_index),
        .peak_valid (peak_valid),
        .peak_lost  (peak_lost)
    );
endmodule

// File: tb/tb_fft_peak_sequencer.sv
// Directed and randomized checks of fft_peak_sequencer against a behavioural model.
module tb_fft_peak_sequencer;
    localparam int DATA_W = 12, IDX_W = 8, STABLE_N = 4, TOL = 1, TMO = 16, CNT_W = 16;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [IDX_W-1:0] peak_index;
    logic             peak_valid, peak_lost, locked, fault;
    logic [CNT_W-1:0] result_count;

    fft_peak_sequencer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    fft_peak_sequencer #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .STABLE_N(STABLE_N), .TOL(TOL),
        .TIMEOUT_SAMPLES(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .stop(stop), .bus(bus),
        .peak_index(peak_index), .peak_valid(peak_valid), .peak_lost(peak_lost),
        .locked(locked), .fault(fault), .result_count(result_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    // Model: mode 0=idle 1=run 2=locked 3=fault
    int m_mode = 0, m_ref = 0, m_agree = 0, m_tmo = 0, m_count = 0;
    bit m_have = 0;
    int e_rx = 0, e_peak = 0;
    bit e_cke = 0, e_pv = 0, e_pl = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit act_st, acc, res;
        int idx, d;
        if (rst) begin
            m_mode = 0; m_ref = 0; m_agree = 0; m_tmo = 0; m_count = 0; m_have = 0;
            e_rx = 0; e_peak = 0; e_cke = 0; e_pv = 0; e_pl = 0;
            return;
        end
        act_st = (m_mode == 1) || (m_mode == 2);
        acc = bus.s_valid && act_st && !stop;
        res = bus.core_valid_out && bus.core_ce_out && act_st && !stop;
        e_cke = acc; e_pv = 0; e_pl = 0;
        if (acc) e_rx = int'(bus.s_data);
        if (stop) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_count = 0; m_tmo = 0; m_have = 0; m_agree = 0; m_ref = 0;
            end
        end else if (act_st) begin
            if (res) begin
                if (m_count < 65535) m_count++;
                m_tmo = 0;
                idx = int'(bus.core_index_max);
                d = (idx > m_ref) ? idx - m_ref : m_ref - idx;
                if (!m_have) begin
                    m_have = 1; m_ref = idx; m_agree = 1;
                end else if (d <= TOL) begin
                    if (m_mode == 1) begin
                        m_agree++;
                        if (m_agree == STABLE_N) begin
                            e_peak = m_ref; e_pv = 1; m_mode = 2;
                        end
                    end
                end else begin
                    if (m_mode == 2) begin
                        e_pl = 1; m_mode = 1;
                    end
                    m_ref = idx; m_agree = 1;
                end
            end else if (acc) begin
                m_tmo++;
                if (m_tmo == TMO) m_mode = 3;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("s_ready", int'(bus.s_ready), int'((m_mode == 1) || (m_mode == 2)));
        chk("core_clk_enable", int'(bus.core_clk_enable), int'(e_cke));
        chk("core_rx_in", int'(bus.core_rx_in), e_rx);
        chk("peak_index", int'(peak_index), e_peak);
        chk("peak_valid", int'(peak_valid), int'(e_pv));
        chk("peak_lost", int'(peak_lost), int'(e_pl));
        chk("locked", int'(locked), int'(m_mode == 2));
        chk("fault", int'(fault), int'(m_mode == 3));
        chk("result_count", int'(result_count), m_count);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send_result(input int idx);
        bus.core_valid_out = 1'b1; bus.core_ce_out = 1'b1; bus.core_index_max = IDX_W'(idx);
        cyc();
        bus.core_valid_out = 1'b0; bus.core_ce_out = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    int base = 128;

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.core_ce_out = 1'b0;
        bus.core_valid_out = 1'b0; bus.core_index_max = '0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("lit_reset_count", int'(result_count), 0);
        chk("lit_reset_ready", int'(bus.s_ready), 0);
        chk("lit_reset_locked", int'(locked), 0);

        // Start, samples every third cycle
        pulse_start();
        chk("lit_ready_after_start", int'(bus.s_ready), 1);
        for (int k = 0; k < 6; k++) begin
            bus.s_valid = 1'b1; bus.s_data = DATA_W'(100 + k * 37);
            cyc();
            bus.s_valid = 1'b0;
            chk("lit_cke_pulse", int'(bus.core_clk_enable), 1);
            chk("lit_rx_data", int'(bus.core_rx_in), 100 + k * 37);
            cyc();
            chk("lit_cke_low", int'(bus.core_clk_enable), 0);
            cyc();
        end

        // Lock on 40, lose to 60, relock on 60
        send_result(40); cyc();
        send_result(41); cyc();
        send_result(40); cyc();
        send_result(39);
        chk("lit_lock_pv", int'(peak_valid), 1);
        chk("lit_lock_idx", int'(peak_index), 40);
        chk("lit_lock_locked", int'(locked), 1);
        chk("lit_lock_count", int'(result_count), 4);
        cyc();
        chk("lit_pv_one_cycle", int'(peak_valid), 0);
        send_result(60);
        chk("lit_lost_pulse", int'(peak_lost), 1);
        chk("lit_lost_unlocked", int'(locked), 0);
        chk("lit_lost_stale_idx", int'(peak_index), 40);
        send_result(60); send_result(60); send_result(60);
        chk("lit_relock_idx", int'(peak_index), 60);
        chk("lit_relock_pv", int'(peak_valid), 1);
        chk("lit_relock_count", int'(result_count), 8);

        // 40 then four 42s: lock on the fifth result
        pulse_stop(); pulse_start();
        send_result(40); send_result(42); send_result(42); send_result(42);
        chk("lit_no_lock_yet", int'(locked), 0);
        send_result(42);
        chk("lit_lock42_idx", int'(peak_index), 42);
        chk("lit_lock42_locked", int'(locked), 1);

        // Timeout after 16 samples without a result
        pulse_stop(); pulse_start();
        bus.s_valid = 1'b1;
        for (int k = 0; k < TMO; k++) begin
            bus.s_data = DATA_W'(k); cyc();
        end
        chk("lit_fault", int'(fault), 1);
        chk("lit_fault_ready", int'(bus.s_ready), 0);
        cyc(); cyc();
        chk("lit_fault_no_cke", int'(bus.core_clk_enable), 0);
        bus.s_valid = 1'b0;
        pulse_stop();
        chk("lit_fault_cleared", int'(fault), 0);

        // Result on the 16th sample wins over the timeout
        pulse_start();
        bus.s_valid = 1'b1;
        for (int k = 0; k < TMO - 1; k++) cyc();
        send_result(50);
        chk("lit_result_beats_tmo", int'(fault), 0);
        cyc();
        bus.s_valid = 1'b0;
        chk("lit_still_running", int'(bus.s_ready), 1);

        // stop with start and a handshake in the same cycle
        start = 1'b1; stop = 1'b1; bus.s_valid = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0; bus.s_valid = 1'b0;
        chk("lit_stop_no_cke", int'(bus.core_clk_enable), 0);
        chk("lit_stop_ready", int'(bus.s_ready), 0);

        // Reset while locked mid-stream, then relock
        pulse_start();
        send_result(40); send_result(40); send_result(40); send_result(40);
        bus.s_valid = 1'b1; bus.s_data = 12'h5A5;
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0; bus.s_valid = 1'b0;
        chk("lit_rst_count", int'(result_count), 0);
        chk("lit_rst_idx", int'(peak_index), 0);
        chk("lit_rst_locked", int'(locked), 0);
        chk("lit_rst_rx", int'(bus.core_rx_in), 0);
        pulse_start();
        send_result(77); send_result(78); send_result(77); send_result(76);
        chk("lit_after_rst_relock", int'(peak_index), 77);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 999) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 7) == 0);
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = DATA_W'($urandom_range(0, 4095));
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 9) == 0) base = int'($urandom_range(2, 253));
                bus.core_valid_out = 1'b1;
                bus.core_ce_out    = ($urandom_range(0, 7) != 0);
                bus.core_index_max = IDX_W'(base + int'($urandom_range(0, 2)) - 1);
            end else begin
                bus.core_valid_out = 1'b0;
                bus.core_ce_out    = 1'($urandom_range(0, 1));
            end
            cyc();
        end
        rst = 1'b0; stop = 1'b0; start = 1'b0;
        bus.s_valid = 1'b0; bus.core_valid_out = 1'b0;
        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
